// File: rtl/mii_command_rx.sv
// MII receive front end: preamble/SFD hunt, byte assembly, FCS and header checks, one command per frame.
// Define MII_MAC_FILTER_EN to accept only broadcast or MAC_ADDR destinations.
//
// state     | meaning
// WAIT_IDLE | after reset, ignore any frame already in progress until mii_DV drops
// IDLE      | between frames, waiting for the first preamble nibble
// PREAMBLE  | counting 5-nibbles, waiting for the SFD nibble d
// DATA      | assembling bytes and running the CRC; evaluated when mii_DV drops
// DROP      | discarding the rest of a bad or oversize frame
module mii_command_rx #(
  parameter logic [15:0] ETHERTYPE = 16'h5555,
  parameter int          MIN_BYTES = 23,
  parameter int          MAX_BYTES = 1522
`ifdef MII_MAC_FILTER_EN
  ,
  parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mii_D,
  input  logic        mii_DV,
  output logic [2:0]  opcode,
  output logic [19:0] command,
  output logic [7:0]  seqnum,
  output logic        strobe,
  output logic        tx_strobe,
  output logic [15:0] frame_ok,
  output logic [7:0]  frame_err
);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    PREAMBLE  = 3'd2,
    DATA      = 3'd3,
    DROP      = 3'd4
  } state_t;

  localparam logic [31:0] CRC_POLY    = 32'hedb88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;
  localparam logic [10:0] MIN_B       = 11'(MIN_BYTES);
  localparam logic [10:0] MAX_B       = 11'(MAX_BYTES);

  state_t      state_q, state_d;
  logic [1:0]  pre_cnt_q, pre_cnt_d;
  logic        odd_q, odd_d;
  logic [3:0]  low_q, low_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] type_q, type_d;
  logic [2:0]  op_sh_q, op_sh_d;
  logic [19:0] cmd_sh_q, cmd_sh_d;
  logic [7:0]  seq_sh_q, seq_sh_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [19:0] command_q, command_d;
  logic [7:0]  seqnum_q, seqnum_d;
  logic        strobe_q, strobe_d;
  logic [15:0] ok_q, ok_d;
  logic [7:0]  err_q, err_d;

  logic [31:0] crc_nib;
  logic [7:0]  byte_val;
  logic [10:0] cnt_inc;
  logic        frame_good;
  logic        mac_ok;
  logic        err_inc;

`ifdef MII_MAC_FILTER_EN
  logic [47:0] dst_q, dst_d;
  assign mac_ok = (dst_q == 48'hffff_ffff_ffff) || (dst_q == MAC_ADDR);
`else
  assign mac_ok = 1'b1;
`endif

  // Reflected CRC-32, four bits per cycle, LSB of the nibble first.
  always_comb begin
    crc_nib = crc_q;
    for (int i = 0; i < 4; i++) begin
      if (crc_nib[0] ^ mii_D[i]) crc_nib = {1'b0, crc_nib[31:1]} ^ CRC_POLY;
      else                       crc_nib = {1'b0, crc_nib[31:1]};
    end
  end

  assign byte_val   = {mii_D, low_q};
  assign cnt_inc    = byte_cnt_q + 11'd1;
  assign frame_good = !odd_q && (byte_cnt_q >= MIN_B) && (crc_q == CRC_RESIDUE) &&
                      (type_q == ETHERTYPE);

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    odd_d      = odd_q;
    low_d      = low_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    type_d     = type_q;
    op_sh_d    = op_sh_q;
    cmd_sh_d   = cmd_sh_q;
    seq_sh_d   = seq_sh_q;
    opcode_d   = opcode_q;
    command_d  = command_q;
    seqnum_d   = seqnum_q;
    strobe_d   = strobe_q;
    ok_d       = ok_q;
    err_inc    = 1'b0;
`ifdef MII_MAC_FILTER_EN
    dst_d      = dst_q;
`endif

    case (state_q)
      WAIT_IDLE: if (!mii_DV) state_d = IDLE;
      IDLE: begin
        if (mii_DV) begin
          if (mii_D == 4'h5) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 2'd1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!mii_DV) begin
          state_d = IDLE;
        end else if (mii_D == 4'h5) begin
          if (pre_cnt_q != 2'd3) pre_cnt_d = pre_cnt_q + 2'd1;
        end else if (mii_D == 4'hd && pre_cnt_q == 2'd3) begin
          state_d    = DATA;
          crc_d      = 32'hffff_ffff;
          byte_cnt_d = 11'd0;
          odd_d      = 1'b0;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (mii_DV) begin
          crc_d = crc_nib;
          if (!odd_q) begin
            low_d = mii_D;
            odd_d = 1'b1;
          end else begin
            odd_d      = 1'b0;
            byte_cnt_d = cnt_inc;
            case (byte_cnt_q)
`ifdef MII_MAC_FILTER_EN
              11'd0, 11'd1, 11'd2,
              11'd3, 11'd4, 11'd5: dst_d = {dst_q[39:0], byte_val};
`endif
              11'd12, 11'd13: type_d = {type_q[7:0], byte_val};
              11'd14: op_sh_d = byte_val[2:0];
              11'd15: cmd_sh_d[7:0]   = byte_val;
              11'd16: cmd_sh_d[15:8]  = byte_val;
              11'd17: cmd_sh_d[19:16] = byte_val[3:0];
              11'd18: seq_sh_d = byte_val;
              default: ;
            endcase
            if (cnt_inc > MAX_B) begin
              state_d = DROP;
              err_inc = 1'b1;
            end
          end
        end else begin
          state_d = IDLE;
          // A frame rejected by the destination filter is silently ignored.
          if (mac_ok) begin
            if (frame_good) begin
              opcode_d  = op_sh_q;
              command_d = cmd_sh_q;
              seqnum_d  = seq_sh_q;
              strobe_d  = ~strobe_q;
              ok_d      = ok_q + 16'd1;
            end else begin
              err_inc = 1'b1;
            end
          end
        end
      end
      DROP: if (!mii_DV) state_d = IDLE;
      default: state_d = WAIT_IDLE;
    endcase

    err_d = (err_inc && err_q != 8'hff) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_IDLE;
      pre_cnt_q  <= 2'd0;
      odd_q      <= 1'b0;
      low_q      <= 4'd0;
      byte_cnt_q <= 11'd0;
      crc_q      <= 32'hffff_ffff;
      type_q     <= 16'd0;
      op_sh_q    <= 3'd0;
      cmd_sh_q   <= 20'd0;
      seq_sh_q   <= 8'd0;
      opcode_q   <= 3'd0;
      command_q  <= 20'd0;
      seqnum_q   <= 8'd0;
      strobe_q   <= 1'b0;
      ok_q       <= 16'd0;
      err_q      <= 8'd0;
`ifdef MII_MAC_FILTER_EN
      dst_q      <= 48'd0;
`endif
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      odd_q      <= odd_d;
      low_q      <= low_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      type_q     <= type_d;
      op_sh_q    <= op_sh_d;
      cmd_sh_q   <= cmd_sh_d;
      seq_sh_q   <= seq_sh_d;
      opcode_q   <= opcode_d;
      command_q  <= command_d;
      seqnum_q   <= seqnum_d;
      strobe_q   <= strobe_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
`ifdef MII_MAC_FILTER_EN
      dst_q      <= dst_d;
`endif
    end
  end

  assign opcode    = opcode_q;
  assign command   = command_q;
  assign seqnum    = seqnum_q;
  assign strobe    = strobe_q;
  assign tx_strobe = strobe_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_mii_command_rx.sv
// Directed bench for mii_command_rx: builds frames with a real FCS and checks outputs/counters.
module tb_mii_command_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mii_D;
  logic        mii_DV;
  logic [2:0]  opcode;
  logic [19:0] command;
  logic [7:0]  seqnum;
  logic        strobe;
  logic        tx_strobe;
  logic [15:0] frame_ok;
  logic [7:0]  frame_err;

  int checks = 0;
  int errors = 0;

  logic [3:0] nib [0:4095];
  int         n_nib;

  always #5 clk = ~clk;

  mii_command_rx dut (
    .clk       (clk),
    .reset     (reset),
    .mii_D     (mii_D),
    .mii_DV    (mii_DV),
    .opcode    (opcode),
    .command   (command),
    .seqnum    (seqnum),
    .strobe    (strobe),
    .tx_strobe (tx_strobe),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  task automatic add_nib(input logic [3:0] d);
    nib[n_nib] = d;
    n_nib += 1;
  endtask

  task automatic add_byte(input logic [7:0] b);
    add_nib(b[3:0]);
    add_nib(b[7:4]);
  endtask

  function automatic logic [31:0] frame_crc();
    logic [31:0] c;
    c = 32'hffff_ffff;
    for (int i = 0; i < n_nib; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (c[0] ^ nib[i][b]) c = (c >> 1) ^ 32'hedb88320;
        else                  c = c >> 1;
      end
    end
    return c;
  endfunction

  task automatic add_fcs(input logic [31:0] flip);
    logic [31:0] f;
    f = ~frame_crc() ^ flip;
    add_byte(f[7:0]);
    add_byte(f[15:8]);
    add_byte(f[23:16]);
    add_byte(f[31:24]);
  endtask

  // total counts bytes from the first dst byte through the last FCS byte
  task automatic build(input logic [47:0] dst, input logic [15:0] etype,
                       input logic [39:0] pay, input int total);
    n_nib = 0;
    for (int i = 0; i < 6; i++) add_byte(dst[47-8*i -: 8]);
    add_byte(8'h02); add_byte(8'h00); add_byte(8'h00);
    add_byte(8'h00); add_byte(8'h00); add_byte(8'h99);
    add_byte(etype[15:8]);
    add_byte(etype[7:0]);
    for (int i = 0; i < 5 && (n_nib / 2) < total - 4; i++) add_byte(pay[39-8*i -: 8]);
    while ((n_nib / 2) < total - 4) add_byte(8'h00);
  endtask

  task automatic send_frame();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); mii_DV = 1'b1; mii_D = 4'h5;
    end
    @(negedge clk); mii_D = 4'hd;
    for (int i = 0; i < n_nib; i++) begin
      @(negedge clk); mii_D = nib[i];
    end
    @(negedge clk); mii_DV = 1'b0; mii_D = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); mii_DV = 1'b0; mii_D = 4'h0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mii_DV = 1'b0; mii_D = 4'h0;
    repeat (3) @(negedge clk);
    checks++; if (opcode !== 3'd0 || command !== 20'd0 || seqnum !== 8'd0) begin
      errors++; $display("FAIL reset_fields got %h %h %h exp 0 0 0", opcode, command, seqnum); end
    checks++; if (strobe !== 1'b0 || tx_strobe !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got %b %b exp 0 0", strobe, tx_strobe); end
    checks++; if (frame_ok !== 16'd0 || frame_err !== 8'd0) begin
      errors++; $display("FAIL reset_counters got %0d %0d exp 0 0", frame_ok, frame_err); end
    reset = 1'b0;
    idle(3);
  endtask

  task automatic test_valid();
    build(48'hffff_ffff_ffff, 16'h5555, 40'h05_34_12_0f_7a, 64);
    add_fcs(32'd0);
    send_frame();
    checks++; if (strobe !== 1'b0) begin
      errors++; $display("FAIL valid_strobe_early got %b exp 0", strobe); end
    @(negedge clk);
    checks++; if (strobe !== 1'b1 || tx_strobe !== 1'b1) begin
      errors++; $display("FAIL valid_strobes got %b %b exp 1 1", strobe, tx_strobe); end
    checks++; if (opcode !== 3'd5) begin
      errors++; $display("FAIL valid_opcode got %h exp 5", opcode); end
    checks++; if (command !== 20'hf1234) begin
      errors++; $display("FAIL valid_command got %h exp f1234", command); end
    checks++; if (seqnum !== 8'h7a) begin
      errors++; $display("FAIL valid_seqnum got %h exp 7a", seqnum); end
    checks++; if (frame_ok !== 16'd1 || frame_err !== 8'd0) begin
      errors++; $display("FAIL valid_counters got %0d %0d exp 1 0", frame_ok, frame_err); end
    idle(3);
  endtask

  task automatic test_bad_fcs();
    build(48'hffff_ffff_ffff, 16'h5555, 40'h06_00_00_00_01, 64);
    add_fcs(32'h0000_0100);
    send_frame();
    idle(2);
    checks++; if (strobe !== 1'b1 || opcode !== 3'd5 || seqnum !== 8'h7a) begin
      errors++; $display("FAIL badfcs_hold got %b %h %h exp 1 5 7a", strobe, opcode, seqnum); end
    checks++; if (frame_err !== 8'd1 || frame_ok !== 16'd1) begin
      errors++; $display("FAIL badfcs_counters got %0d %0d exp 1 1", frame_err, frame_ok); end
  endtask

  task automatic test_bad_type();
    build(48'hffff_ffff_ffff, 16'h0800, 40'h01_00_00_00_02, 64);
    add_fcs(32'd0);
    send_frame();
    idle(2);
    checks++; if (frame_err !== 8'd2 || strobe !== 1'b1) begin
      errors++; $display("FAIL badtype got err %0d strobe %b exp 2 1", frame_err, strobe); end
    build(48'hffff_ffff_ffff, 16'h5555, 40'h03_ef_be_0a_11, 64);
    add_fcs(32'd0);
    send_frame();
    idle(2);
    checks++; if (strobe !== 1'b0 || frame_ok !== 16'd2) begin
      errors++; $display("FAIL type_recover got strobe %b ok %0d exp 0 2", strobe, frame_ok); end
    checks++; if (opcode !== 3'd3 || command !== 20'habeef || seqnum !== 8'h11) begin
      errors++; $display("FAIL type_recover_fields got %h %h %h exp 3 abeef 11", opcode, command, seqnum); end
  endtask

  task automatic test_length();
    build(48'hffff_ffff_ffff, 16'h5555, 40'h01_01_02_03_44, 23);
    add_fcs(32'd0);
    send_frame();
    idle(2);
    checks++; if (frame_ok !== 16'd3 || strobe !== 1'b1) begin
      errors++; $display("FAIL min23 got ok %0d strobe %b exp 3 1", frame_ok, strobe); end
    checks++; if (opcode !== 3'd1 || command !== 20'h30201 || seqnum !== 8'h44) begin
      errors++; $display("FAIL min23_fields got %h %h %h exp 1 30201 44", opcode, command, seqnum); end
    build(48'hffff_ffff_ffff, 16'h5555, 40'h02_00_00_00_55, 22);
    add_fcs(32'd0);
    send_frame();
    idle(2);
    checks++; if (frame_err !== 8'd3 || frame_ok !== 16'd3) begin
      errors++; $display("FAIL short22 got err %0d ok %0d exp 3 3", frame_err, frame_ok); end
    build(48'hffff_ffff_ffff, 16'h5555, 40'h02_00_00_00_56, 64);
    add_nib(4'h3);
    add_fcs(32'd0);
    send_frame();
    idle(2);
    checks++; if (frame_err !== 8'd4 || frame_ok !== 16'd3 || opcode !== 3'd1) begin
      errors++; $display("FAIL odd_nibble got err %0d ok %0d op %h exp 4 3 1", frame_err, frame_ok, opcode); end
  endtask

  task automatic test_back_to_back();
    build(48'hffff_ffff_ffff, 16'h5555, 40'h02_11_22_33_55, 64);
    add_fcs(32'd0);
    send_frame();
    build(48'hffff_ffff_ffff, 16'h5555, 40'h07_aa_bb_cc_66, 64);
    add_fcs(32'd0);
    send_frame();
    idle(2);
    checks++; if (frame_ok !== 16'd5 || strobe !== 1'b1) begin
      errors++; $display("FAIL b2b got ok %0d strobe %b exp 5 1", frame_ok, strobe); end
    checks++; if (opcode !== 3'd7 || command !== 20'hcbbaa || seqnum !== 8'h66) begin
      errors++; $display("FAIL b2b_fields got %h %h %h exp 7 cbbaa 66", opcode, command, seqnum); end
  endtask

  task automatic test_oversize();
    build(48'hffff_ffff_ffff, 16'h5555, 40'h01_00_00_00_77, 1600);
    add_fcs(32'd0);
    send_frame();
    idle(3);
    checks++; if (frame_err !== 8'd5 || frame_ok !== 16'd5) begin
      errors++; $display("FAIL oversize got err %0d ok %0d exp 5 5", frame_err, frame_ok); end
    checks++; if (strobe !== 1'b1 || seqnum !== 8'h66) begin
      errors++; $display("FAIL oversize_hold got %b %h exp 1 66", strobe, seqnum); end
  endtask

  task automatic test_mac_filter();
    logic [15:0] exp_ok;
    logic        exp_strobe;
    logic [2:0]  exp_op;
`ifdef MII_MAC_FILTER_EN
    exp_ok = 16'd5; exp_strobe = 1'b1; exp_op = 3'd7;
`else
    exp_ok = 16'd6; exp_strobe = 1'b0; exp_op = 3'd4;
`endif
    build(48'h02_00_00_00_00_02, 16'h5555, 40'h04_01_00_00_21, 64);
    add_fcs(32'd0);
    send_frame();
    idle(2);
    checks++; if (frame_ok !== exp_ok || strobe !== exp_strobe || opcode !== exp_op) begin
      errors++; $display("FAIL mac_other got %0d %b %h exp %0d %b %h", frame_ok, strobe, opcode, exp_ok, exp_strobe, exp_op); end
    checks++; if (frame_err !== 8'd5) begin
      errors++; $display("FAIL mac_other_err got %0d exp 5", frame_err); end
    build(48'h02_00_00_00_00_01, 16'h5555, 40'h02_00_00_00_22, 64);
    add_fcs(32'd0);
    send_frame();
    idle(2);
    checks++; if (frame_ok !== exp_ok + 16'd1 || strobe !== ~exp_strobe || opcode !== 3'd2 || seqnum !== 8'h22) begin
      errors++; $display("FAIL mac_own got %0d %b %h %h exp %0d %b 2 22", frame_ok, strobe, opcode, seqnum, exp_ok + 16'd1, ~exp_strobe); end
  endtask

  task automatic test_reset_mid();
    build(48'hffff_ffff_ffff, 16'h5555, 40'h06_00_00_00_33, 64);
    add_fcs(32'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); mii_DV = 1'b1; mii_D = 4'h5;
    end
    @(negedge clk); mii_D = 4'hd;
    for (int i = 0; i < n_nib; i++) begin
      @(negedge clk); mii_D = nib[i];
      if (i == 60) reset = 1'b1;
      if (i == 62) begin
        checks++; if (frame_ok !== 16'd0 || frame_err !== 8'd0 || strobe !== 1'b0 || opcode !== 3'd0) begin
          errors++; $display("FAIL midreset_zero got %0d %0d %b %h exp 0 0 0 0", frame_ok, frame_err, strobe, opcode); end
        reset = 1'b0;
      end
    end
    @(negedge clk); mii_DV = 1'b0; mii_D = 4'h0;
    idle(2);
    checks++; if (frame_ok !== 16'd0 || frame_err !== 8'd0 || strobe !== 1'b0) begin
      errors++; $display("FAIL midreset_ignored got %0d %0d %b exp 0 0 0", frame_ok, frame_err, strobe); end
    build(48'hffff_ffff_ffff, 16'h5555, 40'h05_34_12_0f_7a, 64);
    add_fcs(32'd0);
    send_frame();
    idle(2);
    checks++; if (frame_ok !== 16'd1 || strobe !== 1'b1 || command !== 20'hf1234) begin
      errors++; $display("FAIL midreset_next got %0d %b %h exp 1 1 f1234", frame_ok, strobe, command); end
  endtask

  initial begin
    n_nib = 0;
    test_reset();
    test_valid();
    test_bad_fcs();
    test_bad_type();
    test_length();
    test_back_to_back();
    test_oversize();
    test_mac_filter();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
